// File: rtl/arm_mem_pkg.sv
// Shared constants and types for the data-memory write buffer and its backing RAM.
package arm_mem_pkg;

    localparam int DEPTH_DEFAULT     = 4;
    localparam int RAM_WORDS_DEFAULT = 64;
    localparam int IDX_W             = 6;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] index;
        logic [31:0]      data;
    } wbuf_entry_t;

    // What the single RAM port is doing this cycle.
    typedef enum logic [1:0] {
        OP_IDLE,
        OP_LOAD,
        OP_STORE,
        OP_DRAIN
    } op_e;

    function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
        return addr[IDX_W+1:2];
    endfunction

endpackage

// File: rtl/dmem_wbuf_if.sv
// Core-side data memory bus: request, address/data, load result and flow control.
interface dmem_wbuf_if;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Empty;

    modport master (
        output MemWrite, MemRead, ALUResult, WriteData,
        input  ReadData, Stall, Empty
    );

    modport slave (
        input  MemWrite, MemRead, ALUResult, WriteData,
        output ReadData, Stall, Empty
    );
endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM: one shared address, asynchronous read, synchronous write, no reset.
module dmem_ram #(
    parameter int WORDS = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/dmem_wbuf.sv
// Data memory front-end: posted-write FIFO with store-to-load forwarding over a
// single-port RAM. Loads and stores own the port unless the buffer is full.
module dmem_wbuf
    import arm_mem_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEFAULT,
    parameter int RAM_WORDS = RAM_WORDS_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    dmem_wbuf_if.slave bus
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    wbuf_entry_t [DEPTH-1:0] entries;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    op_e               op;
    logic              full, enq, drain;
    logic [IDX_W-1:0]  req_idx;
    logic              fwd_hit;
    logic [31:0]       fwd_data;
    logic [PTR_W-1:0]  slot;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_rdata;

    assign req_idx = word_index(bus.ALUResult);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        wbuf_entry_t entry_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                entry_q.valid <= 1'b0;
            end else if (enq && wr_ptr_q == PTR_W'(gi)) begin
                entry_q <= '{valid: 1'b1, index: req_idx, data: bus.WriteData};
            end else if (drain && rd_ptr_q == PTR_W'(gi)) begin
                entry_q.valid <= 1'b0;
            end
        end

        assign entries[gi] = entry_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // A full buffer takes the port ahead of the core; otherwise loads beat stores.
    always_comb begin
        full = (count_q == FULL_CNT);
        op   = OP_IDLE;
        if (full) begin
            op = OP_DRAIN;
        end else if (bus.MemRead) begin
            op = OP_LOAD;
        end else if (bus.MemWrite) begin
            op = OP_STORE;
        end else if (count_q != '0) begin
            op = OP_DRAIN;
        end
        enq   = (op == OP_STORE);
        drain = (op == OP_DRAIN);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end else if (drain) begin
            rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end
    end

    // Walk oldest to youngest so the last match seen is the most recent store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = PTR_W'((int'(rd_ptr_q) + k) % DEPTH);
            if (entries[slot].valid && entries[slot].index == req_idx) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[slot].data;
            end
        end
    end

    assign ram_addr = drain ? RAM_AW'(entries[rd_ptr_q].index) : RAM_AW'(req_idx);

    dmem_ram #(
        .WORDS(RAM_WORDS),
        .AW   (RAM_AW)
    ) u_ram (
        .clk    (clk),
        .we_i   (drain),
        .addr_i (ram_addr),
        .wdata_i(entries[rd_ptr_q].data),
        .rdata_o(ram_rdata)
    );

    assign bus.Stall    = reset && full && (bus.MemRead || bus.MemWrite);
    assign bus.ReadData = (reset && op == OP_LOAD) ? (fwd_hit ? fwd_data : ram_rdata) : '0;
    assign bus.Empty    = (count_q == '0);
endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed and random checks of dmem_wbuf against a queue-plus-array model of the
// buffered memory; every cycle compares Stall, ReadData and Empty.
module tb_dmem_wbuf;
    import arm_mem_pkg::*;

    localparam int DEPTH = 4;
    localparam int WORDS = 64;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] data;
    } pend_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_wbuf_if bus ();

    dmem_wbuf #(
        .DEPTH    (DEPTH),
        .RAM_WORDS(WORDS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    pend_t       pending[$];
    logic [31:0] ram_m [WORDS];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [31:0] last_rd;
    logic        last_stall;
    logic        last_empty;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [5:0] idx);
        for (int i = pending.size() - 1; i >= 0; i--) begin
            if (pending[i].idx == idx) return pending[i].data;
        end
        return ram_m[idx];
    endfunction

    // One clock cycle: drive, check outputs mid-cycle, advance the model, cross the edge.
    task automatic step(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, output bit accepted);
        logic [5:0]  idx;
        logic [31:0] exp_rd;
        bit          exp_stall;
        bit          exp_empty;
        bus.MemRead   = rd;
        bus.MemWrite  = wr;
        bus.ALUResult = addr;
        bus.WriteData = wd;
        idx       = addr[7:2];
        exp_rd    = '0;
        exp_stall = 1'b0;
        exp_empty = (pending.size() == 0);
        accepted  = 1'b1;
        if (pending.size() == DEPTH) begin
            exp_stall = rd | wr;
            accepted  = !(rd | wr);
        end else if (rd) begin
            exp_rd = model_load(idx);
        end
        #2;
        last_rd    = bus.ReadData;
        last_stall = bus.Stall;
        last_empty = bus.Empty;
        $display("[TB] cyc %0d rd=%0b wr=%0b addr=%h wd=%h -> rdata=%h stall=%0b empty=%0b",
                 cyc, rd, wr, addr, wd, last_rd, last_stall, last_empty);
        check("stall", {31'b0, last_stall}, {31'b0, exp_stall});
        check("rdata", last_rd, exp_rd);
        check("empty", {31'b0, last_empty}, {31'b0, exp_empty});
        if (pending.size() == DEPTH || (!rd && !wr && pending.size() > 0)) begin
            ram_m[pending[0].idx] = pending[0].data;
            pending.delete(0);
        end else if (!rd && wr) begin
            pending.push_back('{idx, wd});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic req(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        bit acc;
        acc = 1'b0;
        for (int n = 0; n < 4 && !acc; n++) step(rd, wr, addr, wd, acc);
    endtask

    task automatic drain_all();
        bit acc;
        for (int n = 0; n < DEPTH + 2 && pending.size() > 0; n++) step(1'b0, 1'b0, '0, '0, acc);
        step(1'b0, 1'b0, '0, '0, acc);
    endtask

    task automatic pulse_reset(input logic [31:0] addr);
        bus.MemRead   = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.ALUResult = addr;
        bus.WriteData = 32'hFFFF_FFFF;
        reset = 1'b0;
        #2;
        check("rst_stall", {31'b0, bus.Stall}, 32'd0);
        check("rst_empty", {31'b0, bus.Empty}, 32'd1);
        check("rst_rdata", bus.ReadData, 32'd0);
        pending.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        logic [31:0] a;
        logic [31:0] d;
        int          r;

        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.ALUResult = '0;
        bus.WriteData = '0;
        #1;
        pulse_reset(32'h0000_0040);

        // First request right after reset release, then forwarded back.
        req(1'b0, 1'b1, 32'h0000_003C, 32'hA5A5_0001);
        req(1'b1, 1'b0, 32'h0000_003C, '0);
        check("first_req_fwd", last_rd, 32'hA5A5_0001);

        // Fill every RAM word with known data; word 12 holds 0x55.
        for (int w = 0; w < WORDS; w++) begin
            d = (w == 12) ? 32'h0000_0055 : $urandom;
            req(1'b0, 1'b1, 32'(w) << 2, d);
        end
        drain_all();

        req(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        req(1'b1, 1'b0, 32'h0000_0010, '0);
        check("fwd_deadbeef", last_rd, 32'hDEAD_BEEF);
        check("fwd_not_empty", {31'b0, last_empty}, 32'd0);
        drain_all();

        req(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0001);
        req(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0002);
        req(1'b1, 1'b0, 32'h0000_0020, '0);
        check("youngest_fwd", last_rd, 32'h0000_0002);
        for (int n = 0; n < 4; n++) step(1'b0, 1'b0, '0, '0, acc);
        req(1'b1, 1'b0, 32'h0000_0020, '0);
        check("same_word_ram", last_rd, 32'h0000_0002);
        check("same_word_empty", {31'b0, last_empty}, 32'd1);

        req(1'b1, 1'b0, 32'h0000_0030, '0);
        check("ram_load", last_rd, 32'h0000_0055);
        check("ram_load_stall", {31'b0, last_stall}, 32'd0);

        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'(i) << 2, 32'h100 + 32'(i), acc);
        step(1'b0, 1'b1, 32'h0000_0010, 32'h0000_0104, acc);
        check("full_stall", {31'b0, last_stall}, 32'd1);
        step(1'b0, 1'b1, 32'h0000_0010, 32'h0000_0104, acc);
        check("full_accept", {31'b0, last_stall}, 32'd0);
        drain_all();
        req(1'b1, 1'b0, 32'h0000_0000, '0);
        check("drained_first", last_rd, 32'h0000_0100);
        req(1'b1, 1'b0, 32'h0000_0010, '0);
        check("drained_fifth", last_rd, 32'h0000_0104);

        // Load and store together: only the load happens.
        req(1'b0, 1'b1, 32'h0000_0008, 32'h0000_0ABC);
        step(1'b1, 1'b1, 32'h0000_0004, 32'h0000_0077, acc);
        step(1'b0, 1'b0, '0, '0, acc);
        step(1'b0, 1'b0, '0, '0, acc);
        check("rw_no_enqueue", {31'b0, last_empty}, 32'd1);
        req(1'b1, 1'b0, 32'h0000_0004, '0);
        check("rw_ram_kept", last_rd, ram_m[1]);

        // Reset discards buffered stores; RAM keeps completed writes.
        for (int i = 0; i < 3; i++) req(1'b0, 1'b1, 32'h40 + (32'(i) << 2), 32'hC0DE_0000 + 32'(i));
        pulse_reset(32'h0000_0040);
        for (int i = 0; i < 3; i++) begin
            req(1'b1, 1'b0, 32'h40 + (32'(i) << 2), '0);
            check("rst_discard", last_rd, ram_m[16 + i]);
        end

        // Random traffic over a few words, with ignored address bits scrambled.
        for (int n = 0; n < 400; n++) begin
            r    = $urandom_range(0, 9);
            a    = $urandom;
            a[7:2] = 6'($urandom_range(0, 7));
            d    = $urandom;
            step(r < 3 || r == 9, r >= 3 && r != 8, a, d, acc);
        end
        drain_all();
        for (int w = 0; w < 8; w++) req(1'b1, 1'b0, 32'(w) << 2, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmem_wbuf.md
DMEM_WBUF -- requirements
Module: dmem_wbuf

Interface
REQ-001 Parameter DEPTH, default 4: number of write-buffer entries (power of two).
REQ-002 Parameter RAM_WORDS, default 64: number of 32-bit words in the backing RAM.
REQ-003 Port clk, input, 1: single clock, rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port MemWrite, input, 1: store request from the core this cycle.
REQ-006 Port MemRead, input, 1: load request from the core this cycle.
REQ-007 Port ALUResult, input, 32: byte address; word index is ALUResult[7:2], other bits ignored.
REQ-008 Port WriteData, input, 32: store data.
REQ-009 Port ReadData, output, 32: load data, combinational.
REQ-010 Port Stall, output, 1: request not accepted this cycle; core holds PC and inputs.
REQ-011 Port Empty, output, 1: write buffer holds no valid entries.

Function
REQ-012 The block SHALL hold a FIFO write buffer of DEPTH entries {word index, data}, with wrap-around read/write pointers and a count 0..DEPTH.
REQ-013 The backing RAM SHALL be single-port: at most one read or one write per cycle.
REQ-014 Per-cycle priority: (1) count==DEPTH -> forced drain; (2) else MemRead -> load; (3) else MemWrite -> enqueue; (4) else idle -> drain if count>0.
REQ-015 Forced drain: oldest entry written to RAM at the clock edge, count decrements, Stall = MemRead|MemWrite, ReadData = 0, no enqueue.
REQ-016 Load: ReadData SHALL be the data of the youngest valid buffer entry whose word index matches; if none matches, the RAM word; Stall=0; no drain.
REQ-017 Enqueue: at the clock edge, {ALUResult[7:2], WriteData} is written at the write pointer and count increments; Stall=0; no drain.
REQ-018 Idle drain: the oldest entry is written to RAM at the clock edge and count decrements.
REQ-019 MemRead and MemWrite both high SHALL be treated as a load only; the store is not recorded, and Stall=0.
REQ-020 Multiple entries to the same word SHALL drain in order, so the RAM holds the last-stored value.
REQ-021 ReadData SHALL be 0 when MemRead=0.
REQ-022 Empty SHALL equal (count==0), combinationally.
REQ-023 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.

Reset
REQ-024 While reset is low: pointers and count = 0, all valid bits cleared, Stall=0, Empty=1, ReadData=0.
REQ-025 Asserting reset mid-operation SHALL discard all undrained entries; RAM contents are not reset and keep all completed writes.
REQ-026 The first request SHALL be honoured on the first rising edge after reset deasserts.

Structure
REQ-027 Shared package arm_mem_pkg SHALL hold DEPTH and RAM_WORDS defaults, the word-index width constant and the buffer entry typedef {valid, index[5:0], data[31:0]}.
REQ-028 The RAM SHALL be a separate sub-module dmem_ram (single port, asynchronous read, synchronous write); buffer, forwarding and arbitration stay in dmem_wbuf.

Verification
REQ-029 Store 0xDEADBEEF to 0x10, then load 0x10 in the next cycle -> ReadData=0xDEADBEEF forwarded, Empty=0.
REQ-030 Store 0x1 then 0x2 to 0x20, then load 0x20 -> 0x2; after idle cycles RAM[8]=0x2 and Empty=1.
REQ-031 Five consecutive stores to 0x00,0x04,0x08,0x0C,0x10 -> fifth cycle Stall=1 with count=4; one forced drain, then the fifth store is accepted.
REQ-032 Load 0x30 with buffer empty and RAM[12]=0x55 -> ReadData=0x55, Stall=0.
REQ-033 Three stores buffered, reset pulsed low -> Empty=1; a load of those addresses returns the prior RAM values.
REQ-034 MemRead=MemWrite=1 to 0x04 with data 0x77 -> load result returned, buffer count unchanged.
